ifetch_ctrl: RTL and testbench

- Instruction-fetch controller directly downstream of the program-counter register.
- Takes the current PC, issues a request to instruction memory over a req/gnt + rvalid handshake, and delivers one instruction per fetch to decode with a one-cycle valid pulse.
- Drives fetch_stall back to the next-PC logic so the PC holds while a fetch is outstanding.
- Detects misaligned PC, memory access error and response timeout, and reports each as a fault.

---
 rtl/ifetch_ctrl.sv | 133 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one imem request per PC, one instruction delivered to decode.
// Latency: 3 cycles minimum (REQ with gnt, WAIT with rvalid, DELIVER); instr fields registered.
// Backpressure: fetch_stall holds the PC in every state except DELIVER; imem_gnt stalls REQ.
module ifetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic             WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ERR   = 2'b10;
    localparam logic [1:0] CAUSE_TMO   = 2'b11;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      instr_pc_q, instr_pc_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             drain_pend_q, drain_pend_d;

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        wd_d         = wd_q;
        drain_pend_d = drain_pend_q;
        case (state_q)
            S_REQ: begin
                if (pc[1:0] != 2'b00) begin
                    instr_d    = NOP_INSTR;
                    instr_pc_d = pc;
                    fault_d    = 1'b1;
                    cause_d    = CAUSE_ALIGN;
                    state_d    = S_DELIVER;
                end else if (imem_gnt) begin
                    instr_pc_d = pc;
                    wd_d       = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush without the response still owes us one rvalid, so it must be drained.
                if (flush) begin
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    instr_d = imem_err ? NOP_INSTR : imem_rdata;
                    fault_d = imem_err;
                    cause_d = imem_err ? CAUSE_ERR : CAUSE_NONE;
                    state_d = S_DELIVER;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    instr_d      = NOP_INSTR;
                    fault_d      = 1'b1;
                    cause_d      = CAUSE_TMO;
                    drain_pend_d = 1'b1;
                    state_d      = S_DELIVER;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DELIVER: begin
                state_d = drain_pend_q ? S_DRAIN : S_REQ;
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    drain_pend_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= 32'h0;
            fault_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
            wd_q         <= '0;
            drain_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            wd_q         <= wd_d;
            drain_pend_q <= drain_pend_d;
        end
    end

    assign imem_req    = !rst && (state_q == S_REQ) && (pc[1:0] == 2'b00);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign instr_valid = (state_q == S_DELIVER);
    assign fetch_stall = (state_q != S_DELIVER);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a 4-cycle watchdog.
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        fetch_stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(.NOP_INSTR(NOP), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fault(fault), .fault_cause(fault_cause), .fetch_stall(fetch_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after posedge; outputs are observed at negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] p, input logic g, input logic rv,
                         input logic [31:0] rd, input logic er, input logic fl);
        pc = p; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; imem_err = er; flush = fl;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                            input logic ef, input logic [1:0] ec);
        chk({tag, "_vld"},   32'(instr_valid), 32'd1);
        chk({tag, "_stall"}, 32'(fetch_stall), 32'd0);
        chk({tag, "_instr"}, instr, ei);
        chk({tag, "_pc"},    instr_pc, ep);
        chk({tag, "_fault"}, 32'(fault), 32'(ef));
        chk({tag, "_cause"}, 32'(fault_cause), 32'(ec));
    endtask

    int req_cnt;
    int vld_cnt;

    initial begin
        rst = 1'b1;
        drive(32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_ipc",   instr_pc, 32'h0);
        chk("rst_vld",   32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        step();
        rst = 1'b0;

        // zero-wait fetch
        drive(32'h1000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("zw_req",   32'(imem_req), 32'd1);
        chk("zw_addr",  imem_addr, 32'h1000);
        chk("zw_stall", 32'(fetch_stall), 32'd1);
        step();
        drive(32'h1000, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0);
        mid();
        chk("zw_wait_req", 32'(imem_req), 32'd0);
        chk("zw_wait_vld", 32'(instr_valid), 32'd0);
        step();
        drive(32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk_slot("zw", 32'h00500093, 32'h1000, 1'b0, 2'b00);
        step();
        drive(32'h1004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("zw2_req",  32'(imem_req), 32'd1);
        chk("zw2_addr", imem_addr, 32'h1004);
        step();
        drive(32'h1004, 1'b0, 1'b1, 32'h00208133, 1'b0, 1'b0);
        step();
        drive(32'h1004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk_slot("zw2", 32'h00208133, 32'h1004, 1'b0, 2'b00);
        step();

        // grant delayed 4 cycles, response 2 cycles after grant
        req_cnt = 0;
        vld_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h1008, (i == 4), (i == 6), 32'h00A00113, 1'b0, 1'b0);
            mid();
            req_cnt += int'(imem_req);
            vld_cnt += int'(instr_valid);
            chk($sformatf("gd_stall%0d", i), 32'(fetch_stall), 32'((i != 7)));
            if (i == 7) chk_slot("gd", 32'h00A00113, 32'h1008, 1'b0, 2'b00);
            step();
        end
        chk("gd_req_cnt", 32'(req_cnt), 32'd5);
        chk("gd_vld_cnt", 32'(vld_cnt), 32'd1);

        // misaligned pc
        drive(32'h1002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("mis_req", 32'(imem_req), 32'd0);
        step();
        mid();
        chk_slot("mis", NOP, 32'h1002, 1'b1, 2'b01);
        step();

        // access error
        drive(32'h100C, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h100C, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        step();
        drive(32'h100C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk_slot("err", NOP, 32'h100C, 1'b1, 2'b10);
        step();

        // watchdog timeout, late response drained
        drive(32'h1010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h1010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("tmo_wait%0d_vld", i), 32'(instr_valid), 32'd0);
            step();
        end
        mid();
        chk_slot("tmo", NOP, 32'h1010, 1'b1, 2'b11);
        step();
        drive(32'h1014, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mid();
            chk($sformatf("drn%0d_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("drn%0d_stall", i), 32'(fetch_stall), 32'd1);
            step();
        end
        drive(32'h1014, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        drive(32'h1014, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("drn_out_req",   32'(imem_req), 32'd1);
        chk("drn_out_vld",   32'(instr_valid), 32'd0);
        chk("drn_out_instr", instr, NOP);
        imem_gnt = 1'b1;
        step();
        drive(32'h1014, 1'b0, 1'b1, 32'h00000033, 1'b0, 1'b0);
        step();
        drive(32'h1014, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk_slot("post_tmo", 32'h00000033, 32'h1014, 1'b0, 2'b00);
        step();

        // flush in WAIT, response 2 cycles later is dropped
        drive(32'h1018, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        drive(32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("fl_drn_req", 32'(imem_req), 32'd0);
        chk("fl_drn_vld", 32'(instr_valid), 32'd0);
        step();
        drive(32'h2000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        mid();
        chk("fl_rv_vld", 32'(instr_valid), 32'd0);
        step();
        drive(32'h2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("fl_req",   32'(imem_req), 32'd1);
        chk("fl_addr",  imem_addr, 32'h2000);
        chk("fl_vld",   32'(instr_valid), 32'd0);
        step();
        drive(32'h2000, 1'b0, 1'b1, 32'h00100073, 1'b0, 1'b0);
        step();
        drive(32'h2000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk_slot("fl", 32'h00100073, 32'h2000, 1'b0, 2'b00);
        step();

        // flush and response in the same WAIT cycle
        drive(32'h2004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(32'h3000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        step();
        drive(32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mid();
        chk("flrv_req",   32'(imem_req), 32'd1);
        chk("flrv_vld",   32'(instr_valid), 32'd0);
        chk("flrv_instr", instr, 32'h00100073);
        chk("flrv_addr",  imem_addr, 32'h3000);

        // reset mid-WAIT with responses during and after reset
        imem_gnt = 1'b1;
        step();
        drive(32'h1000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        rst = 1'b1;
        mid();
        chk("rw_req",   32'(imem_req), 32'd0);
        chk("rw_vld",   32'(instr_valid), 32'd0);
        chk("rw_instr", instr, NOP);
        chk("rw_ipc",   instr_pc, 32'h0);
        chk("rw_fault", 32'(fault), 32'd0);
        chk("rw_cause", 32'(fault_cause), 32'd0);
        step();
        rst = 1'b0;
        mid();
        chk("rw_post_req",  32'(imem_req), 32'd1);
        chk("rw_post_addr", imem_addr, 32'h1000);
        chk("rw_post_vld",  32'(instr_valid), 32'd0);
        step();
        imem_rvalid = 1'b0;
        mid();
        chk("rw_post2_vld",   32'(instr_valid), 32'd0);
        chk("rw_post2_req",   32'(imem_req), 32'd1);
        chk("rw_post2_instr", instr, NOP);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
